// File: rtl/mips_mc_control_pkg.sv
// Shared definitions for the multicycle MIPS control unit:
//   - state encodings (also exported on the State debug port)
//   - supported opcodes
//   - ALUOp / ALUSrcB / PCSrc codes
//   - ctrl_t, the bundle of every datapath control output
package mips_mc_control_pkg;

  localparam int OPW = 6;  // opcode width, Instr[31:26]
  localparam int STW = 4;  // state register width

  typedef enum logic [STW-1:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEX   = 4'd7,
    S_RTWB   = 4'd8,
    S_BEQ    = 4'd9,
    S_JMP    = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
  } state_e;

  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B        = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_SEXT     = 2'b10;
  localparam logic [1:0] SRCB_SEXT_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_supported(input logic [OPW-1:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_mc_control_if.sv
// Control bus between the multicycle control FSM and the datapath.
//   master : control unit (drives selects/enables, samples Opcode/Zero/MemReady)
//   slave  : datapath side (drives Opcode/Zero/MemReady, samples the controls)
interface mips_mc_control_if;
  import mips_mc_control_pkg::*;

  logic [OPW-1:0] Opcode;
  logic           Zero;
  logic           MemReady;

  logic           RegDst;
  logic           MemtoReg;
  logic           RegWrite;
  logic           IorD;
  logic           MemRead;
  logic           MemWrite;
  logic           IRWrite;
  logic           PCWrite;
  logic           PCWriteCond;
  logic [1:0]     PCSrc;
  logic           ALUSrcA;
  logic [1:0]     ALUSrcB;
  logic [1:0]     ALUOp;
  logic           InstrDone;
  logic           Illegal;
  logic [STW-1:0] State;

  modport master (
    input  Opcode, Zero, MemReady,
    output RegDst, MemtoReg, RegWrite, IorD, MemRead, MemWrite, IRWrite,
           PCWrite, PCWriteCond, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
           InstrDone, Illegal, State
  );

  modport slave (
    output Opcode, Zero, MemReady,
    input  RegDst, MemtoReg, RegWrite, IorD, MemRead, MemWrite, IRWrite,
           PCWrite, PCWriteCond, PCSrc, ALUSrcA, ALUSrcB, ALUOp,
           InstrDone, Illegal, State
  );

endinterface

// File: rtl/mips_mc_control_outdec.sv
// mips_ctrl_outdec: purely combinational decode of the control state into
// datapath controls.
//   state     in  current FSM state
//   mem_ready in  memory handshake (only used in FETCH and MEMWR)
//   opcode    in  IR[31:26], only used in DECODE for the Illegal flag
//   ctrl      out all control outputs; zero for IDLE and unused encodings
module mips_ctrl_outdec
  import mips_mc_control_pkg::*;
(
  input  state_e         state,
  input  logic           mem_ready,
  input  logic [OPW-1:0] opcode,
  output ctrl_t          ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        // IR load and PC+4 only happen on the cycle memory delivers.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_SEXT_SH2;
        ctrl.illegal   = ~is_supported(opcode);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_RTEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_SEXT;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// mips_mc_control: multicycle MIPS control FSM.
//   clk      in  system clock, rising edge
//   reset_n  in  asynchronous active-low reset, forces IDLE
//   bus      master side of mips_mc_control_if (Opcode/Zero/MemReady in,
//            all datapath selects/enables, InstrDone, Illegal, State out)
//
// state  | meaning
// IDLE   | after reset, all outputs 0
// FETCH  | read instruction at PC, PC+4; wait for MemReady
// DECODE | register read, branch target; dispatch on opcode
// MEMADR | lw/sw effective address
// MEMRD  | lw data read; wait for MemReady
// MEMWB  | lw writeback to rt
// MEMWR  | sw data write; wait for MemReady
// RTEX   | R-type ALU operation
// RTWB   | R-type writeback to rd
// BEQ    | compare, conditional PC load
// JMP    | jump target to PC
// ADDIEX | addi ALU operation
// ADDIWB | addi writeback to rt
module mips_mc_control
  import mips_mc_control_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  mips_mc_control_if.master bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = bus.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.Opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTEX;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JMP;
          OP_ADDI:      state_d = S_ADDIEX;
          default:      state_d = S_FETCH;
        endcase
      end
      // Only lw and sw reach MEMADR, so anything not sw is a load.
      S_MEMADR: state_d = (bus.Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = bus.MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = bus.MemReady ? S_FETCH : S_MEMWR;
      S_RTEX:   state_d = S_RTWB;
      S_RTWB:   state_d = S_FETCH;
      S_BEQ:    state_d = S_FETCH;
      S_JMP:    state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (bus.MemReady),
    .opcode    (bus.Opcode),
    .ctrl      (ctrl)
  );

  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.IorD        = ctrl.i_or_d;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.PCSrc       = ctrl.pc_src;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.InstrDone   = ctrl.instr_done;
  assign bus.Illegal     = ctrl.illegal;
  assign bus.State       = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
module tb_mips_mc_control;
  import mips_mc_control_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;

  mips_mc_control_if bus ();

  mips_mc_control dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Tracks the current step and a queue of remaining steps of the
  // instruction, planned in DECODE from the opcode.
  state_e m_state = S_IDLE;
  state_e m_q[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_state <= S_IDLE;
      m_q.delete();
    end else begin
      case (m_state)
        S_FETCH: if (bus.MemReady) m_state <= S_DECODE;
        S_DECODE: begin
          case (bus.Opcode)
            OP_LW:    begin m_state <= S_MEMADR; m_q.push_back(S_MEMRD); m_q.push_back(S_MEMWB); end
            OP_SW:    begin m_state <= S_MEMADR; m_q.push_back(S_MEMWR); end
            OP_RTYPE: begin m_state <= S_RTEX;   m_q.push_back(S_RTWB); end
            OP_BEQ:   m_state <= S_BEQ;
            OP_J:     m_state <= S_JMP;
            OP_ADDI:  begin m_state <= S_ADDIEX; m_q.push_back(S_ADDIWB); end
            default:  m_state <= S_FETCH;
          endcase
        end
        S_MEMRD, S_MEMWR: begin
          if (bus.MemReady) begin
            if (m_q.size() > 0) m_state <= m_q.pop_front();
            else                m_state <= S_FETCH;
          end
        end
        default: begin
          if (m_q.size() > 0) m_state <= m_q.pop_front();
          else                m_state <= S_FETCH;
        end
      endcase
    end
  end

  // Expected outputs written as properties of groups of steps.
  function automatic ctrl_t exp_ctrl(state_e s, logic mr, logic [5:0] op);
    ctrl_t c;
    logic  known;
    known = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
            (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    c = '0;
    c.mem_read      = (s == S_FETCH) || (s == S_MEMRD);
    c.i_or_d        = (s == S_MEMRD) || (s == S_MEMWR);
    c.mem_write     = (s == S_MEMWR);
    c.ir_write      = (s == S_FETCH) && mr;
    c.pc_write      = ((s == S_FETCH) && mr) || (s == S_JMP);
    c.pc_write_cond = (s == S_BEQ);
    c.pc_src        = (s == S_BEQ) ? 2'b01 : (s == S_JMP) ? 2'b10 : 2'b00;
    c.alu_src_a     = (s == S_MEMADR) || (s == S_RTEX) || (s == S_BEQ) || (s == S_ADDIEX);
    c.alu_src_b     = (s == S_FETCH) ? 2'b01 : (s == S_DECODE) ? 2'b11 :
                      ((s == S_MEMADR) || (s == S_ADDIEX)) ? 2'b10 : 2'b00;
    c.alu_op        = (s == S_RTEX) ? 2'b10 : (s == S_BEQ) ? 2'b01 : 2'b00;
    c.reg_write     = (s == S_MEMWB) || (s == S_RTWB) || (s == S_ADDIWB);
    c.reg_dst       = (s == S_RTWB);
    c.mem_to_reg    = (s == S_MEMWB);
    c.instr_done    = (s == S_MEMWB) || (s == S_RTWB) || (s == S_BEQ) ||
                      (s == S_JMP) || (s == S_ADDIWB) || ((s == S_MEMWR) && mr);
    c.illegal       = (s == S_DECODE) && !known;
    return c;
  endfunction

  function automatic ctrl_t dut_ctrl();
    ctrl_t c;
    c.reg_dst       = bus.RegDst;
    c.mem_to_reg    = bus.MemtoReg;
    c.reg_write     = bus.RegWrite;
    c.i_or_d        = bus.IorD;
    c.mem_read      = bus.MemRead;
    c.mem_write     = bus.MemWrite;
    c.ir_write      = bus.IRWrite;
    c.pc_write      = bus.PCWrite;
    c.pc_write_cond = bus.PCWriteCond;
    c.pc_src        = bus.PCSrc;
    c.alu_src_a     = bus.ALUSrcA;
    c.alu_src_b     = bus.ALUSrcB;
    c.alu_op        = bus.ALUOp;
    c.instr_done    = bus.InstrDone;
    c.illegal       = bus.Illegal;
    return c;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    ctrl_t e, a;
    logic  e_pcload, a_pcload;
    e = exp_ctrl(m_state, bus.MemReady, bus.Opcode);
    a = dut_ctrl();
    checks++;
    if (a !== e || bus.State !== 4'(m_state)) begin
      failures++;
      $display("FAIL cycle_cmp t=%0t state act=%0d exp=%0d ctrl act=%h exp=%h",
               $time, bus.State, m_state, a, e);
    end
    checks++;
    if (a.reg_write && (a.mem_read || a.mem_write)) begin
      failures++;
      $display("FAIL regwrite_vs_mem t=%0t act RegWrite=%b MemRead=%b MemWrite=%b required no overlap",
               $time, a.reg_write, a.mem_read, a.mem_write);
    end
    e_pcload = e.pc_write | (e.pc_write_cond & bus.Zero);
    a_pcload = a.pc_write | (a.pc_write_cond & bus.Zero);
    checks++;
    if (a_pcload !== e_pcload) begin
      failures++;
      $display("FAIL pc_load t=%0t act=%b exp=%b", $time, a_pcload, e_pcload);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction starting in FETCH. mr_pat bit i is MemReady for
  // cycle i+1 of the instruction. Returns cycle count and the controls seen
  // on the final (InstrDone or Illegal) cycle.
  task automatic run_instr(input string name, input logic [5:0] op, input logic z,
                           input logic [15:0] mr_pat, input int exp_cycles,
                           output ctrl_t last, output int n_memwrite,
                           output int n_irwrite, output int n_wr);
    int cyc;
    bit done;
    cyc = 1; done = 0; n_memwrite = 0; n_irwrite = 0; n_wr = 0; last = '0;
    bus.Opcode = op;
    bus.Zero = z;
    bus.MemReady = mr_pat[0];
    for (int i = 0; i < 24 && !done; i++) begin
      @(negedge clk);
      if (bus.MemWrite) n_memwrite++;
      if (bus.IRWrite && bus.PCWrite) n_irwrite++;
      if (bus.RegWrite || bus.MemWrite) n_wr++;
      if (bus.InstrDone || bus.Illegal) begin
        done = 1;
        last = dut_ctrl();
      end
      @(posedge clk);
      #1;
      if (!done) begin
        cyc++;
        bus.MemReady = (cyc <= 16) ? mr_pat[cyc-1] : 1'b1;
      end
    end
    checks++;
    if (!done || cyc != exp_cycles) begin
      failures++;
      $display("FAIL %s_cycles act=%0d exp=%0d done=%0b", name, cyc, exp_cycles, done);
    end
  endtask

  initial begin
    ctrl_t last;
    int    nmw, nir, nwr;

    reset_n = 1'b0;
    bus.Opcode = 6'b0;
    bus.Zero = 1'b0;
    bus.MemReady = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    check("idle_state", 32'(bus.State), 32'(S_IDLE));
    check("idle_outputs", 32'(dut_ctrl()), 32'h0);
    step();
    check("fetch_after_idle", 32'(bus.State), 32'(S_FETCH));
    check("fetch_memread", 32'(bus.MemRead), 32'h1);

    // lw: 5 cycles, MEMWB writes rt from MDR
    run_instr("lw", OP_LW, 1'b0, 16'hFFFF, 5, last, nmw, nir, nwr);
    check("lw_regwrite", 32'(last.reg_write), 32'h1);
    check("lw_regdst", 32'(last.reg_dst), 32'h0);
    check("lw_memtoreg", 32'(last.mem_to_reg), 32'h1);

    // R-type, then R-type with MemReady low outside memory states
    run_instr("rtype", OP_RTYPE, 1'b0, 16'hFFFF, 4, last, nmw, nir, nwr);
    check("rtype_regdst", 32'(last.reg_dst), 32'h1);
    check("rtype_regwrite", 32'(last.reg_write), 32'h1);
    run_instr("rtype_mr_low", OP_RTYPE, 1'b0, 16'h0001, 4, last, nmw, nir, nwr);

    // back-to-back addi
    run_instr("addi0", OP_ADDI, 1'b0, 16'hFFFF, 4, last, nmw, nir, nwr);
    check("addi0_regdst", 32'(last.reg_dst), 32'h0);
    run_instr("addi1", OP_ADDI, 1'b0, 16'hFFFF, 4, last, nmw, nir, nwr);
    check("addi1_regwrite", 32'(last.reg_write), 32'h1);
    check("addi1_memtoreg", 32'(last.mem_to_reg), 32'h0);

    // fetch stalled for 3 cycles
    run_instr("fetch_stall", OP_RTYPE, 1'b0, 16'hFFF8, 7, last, nmw, nir, nwr);
    check("fetch_stall_irwrite_cycles", 32'(nir), 32'h1);

    // sw with 2 stall cycles in MEMWR, then unstalled sw
    run_instr("sw_stall", OP_SW, 1'b0, 16'hFFE7, 6, last, nmw, nir, nwr);
    check("sw_stall_memwrite_cycles", 32'(nmw), 32'h3);
    check("sw_stall_done_with_write", 32'(last.mem_write), 32'h1);
    run_instr("sw", OP_SW, 1'b0, 16'hFFFF, 4, last, nmw, nir, nwr);

    // branch and jump
    run_instr("beq", OP_BEQ, 1'b1, 16'hFFFF, 3, last, nmw, nir, nwr);
    check("beq_pcwritecond", 32'(last.pc_write_cond), 32'h1);
    check("beq_pcsrc", 32'(last.pc_src), 32'h1);
    run_instr("j", OP_J, 1'b0, 16'hFFFF, 3, last, nmw, nir, nwr);
    check("j_pcwrite", 32'(last.pc_write), 32'h1);
    check("j_pcsrc", 32'(last.pc_src), 32'h2);

    // unsupported opcode
    run_instr("illegal", 6'b111111, 1'b0, 16'hFFFF, 2, last, nmw, nir, nwr);
    check("illegal_flag", 32'(last.illegal), 32'h1);
    check("illegal_no_writes", 32'(nwr), 32'h0);
    check("illegal_back_to_fetch", 32'(bus.State), 32'(S_FETCH));

    // reset asserted in the middle of a stalled lw read
    bus.Opcode = OP_LW;
    bus.MemReady = 1'b1;
    step();
    step();
    step();
    bus.MemReady = 1'b0;
    check("pre_reset_memrd", 32'(bus.State), 32'(S_MEMRD));
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_outputs_immediate", 32'(dut_ctrl()), 32'h0);
    check("reset_state_immediate", 32'(bus.State), 32'(S_IDLE));
    step();
    reset_n = 1'b1;
    check("post_reset_idle", 32'(bus.State), 32'(S_IDLE));
    step();
    check("post_reset_fetch", 32'(bus.State), 32'(S_FETCH));
    check("post_reset_memread", 32'(bus.MemRead), 32'h1);
    run_instr("lw_after_reset", OP_LW, 1'b0, 16'hFFFF, 5, last, nmw, nir, nwr);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
